// File: rtl/async_sync_pkg.sv
`default_nettype none
// ============================================================================
// async_sync_pkg : shared types and limits for the multi-channel synchronizer
// Rev 1.0
// ============================================================================
package async_sync_pkg;

  typedef enum logic {
    SYNC_LEVEL  = 1'b0,
    SYNC_TOGGLE = 1'b1
  } sync_mode_e;

  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 8;

endpackage
`default_nettype wire

// File: rtl/async_sync_chain.sv
`default_nettype none
// ============================================================================
// async_sync_chain : one DEPTH-stage synchronizer for a single async bit
// Rev 1.0
// ============================================================================
module async_sync_chain
  import async_sync_pkg::*;
#(
  parameter int   DEPTH = 3,
  parameter logic INIT  = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic io_d,
  output logic io_q
);

  // Stage 0 is the metastability-capturing flop; all stages are tagged for CDC tools.
  (* async_reg = "true" *) logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= {DEPTH{INIT}};
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], io_d};
    end
  end

  assign io_q = r_sync[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/async_valid_sync_multi.sv
`default_nettype none
// ============================================================================
// async_valid_sync_multi : WIDTH-channel async level/toggle synchronizer with
//                          rise/fall/pulse detection and post-reset warm-up
// Rev 1.0
// ============================================================================
module async_valid_sync_multi
  import async_sync_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 3,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter sync_mode_e       MODE  = SYNC_LEVEL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic [WIDTH-1:0] io_pulse,
  output logic             io_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_WARM  = 1'b0,
    ST_READY = 1'b1
  } warm_state_e;

  generate
    if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("async_valid_sync_multi: DEPTH must be within 2..8");
    end
  endgenerate

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_ready_mask;
  logic [WIDTH-1:0] r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  warm_state_e      r_state;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chain
      async_sync_chain #(
        .DEPTH (DEPTH),
        .INIT  (INIT[gi])
      ) u_chain (
        .clock (clock),
        .reset (reset),
        .io_d  (io_in[gi]),
        .io_q  (w_sync[gi])
      );
    end
  endgenerate

  // prev tracks io_out even while warming so no stale edge fires on READY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev <= INIT;
    end else begin
      r_prev <= w_sync;
    end
  end

  // Warm-up: ready asserts on the DEPTH-th edge after release, when the chains hold only post-reset samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_WARM;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_WARM: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DEPTH - 1)) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_READY: begin
          r_cnt   <= r_cnt;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_WARM;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign w_ready_mask = {WIDTH{r_ready}};
  assign io_out       = w_sync;
  assign io_ready     = r_ready;
  assign io_rise      =  w_sync & ~r_prev & w_ready_mask;
  assign io_fall      = ~w_sync &  r_prev & w_ready_mask;

  generate
    if (MODE == SYNC_TOGGLE) begin : g_toggle
      assign io_pulse = (w_sync ^ r_prev) & w_ready_mask;
    end else begin : g_level
      assign io_pulse = io_rise;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_async_valid_sync_multi.sv
`default_nettype none
// ============================================================================
// tb_async_valid_sync_multi : randomized + directed bench against a history model
// Rev 1.0
// ============================================================================
module tb_async_valid_sync_multi;
  import async_sync_pkg::*;

  localparam int         W      = 4;
  localparam int         D      = 3;
  localparam logic [3:0] INIT_L = 4'b0000;
  localparam logic [3:0] INIT_T = 4'b0110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_v = '0;

  logic [3:0] l_out, l_rise, l_fall, l_pulse;
  logic       l_ready;
  logic [3:0] t_out, t_rise, t_fall, t_pulse;
  logic       t_ready;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  async_valid_sync_multi #(
    .WIDTH (W), .DEPTH (D), .INIT (INIT_L), .MODE (SYNC_LEVEL)
  ) dut_lvl (
    .clock (clk), .reset (rst), .io_in (in_v),
    .io_out (l_out), .io_rise (l_rise), .io_fall (l_fall),
    .io_pulse (l_pulse), .io_ready (l_ready)
  );

  async_valid_sync_multi #(
    .WIDTH (W), .DEPTH (D), .INIT (INIT_T), .MODE (SYNC_TOGGLE)
  ) dut_tog (
    .clock (clk), .reset (rst), .io_in (in_v),
    .io_out (t_out), .io_rise (t_rise), .io_fall (t_fall),
    .io_pulse (t_pulse), .io_ready (t_ready)
  );

  // Model: io_out is the input sampled D edges ago, or INIT until D edges have elapsed since reset.
  logic [3:0]  hist [0:D];
  int unsigned edges = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_out(input logic [3:0] init);
    return (edges >= D) ? hist[D-1] : init;
  endfunction

  function automatic logic [3:0] m_prev(input logic [3:0] init);
    return (edges >= D + 1) ? hist[D] : init;
  endfunction

  function automatic logic m_ready();
    return edges >= D;
  endfunction

  task automatic check_all();
    logic [3:0] o, p, m, r, f;
    m = {4{m_ready()}};
    o = m_out(INIT_L); p = m_prev(INIT_L);
    r = o & ~p & m;    f = ~o & p & m;
    chk("lvl_out", l_out, o);
    chk("lvl_rise", l_rise, r);
    chk("lvl_fall", l_fall, f);
    chk("lvl_pulse", l_pulse, r);
    chk("lvl_ready", l_ready, m_ready());
    o = m_out(INIT_T); p = m_prev(INIT_T);
    chk("tog_out", t_out, o);
    chk("tog_rise", t_rise, o & ~p & m);
    chk("tog_fall", t_fall, ~o & p & m);
    chk("tog_pulse", t_pulse, (o ^ p) & m);
    chk("tog_ready", t_ready, m_ready());
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      for (int k = D; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_v;
      if (edges < 1000) edges++;
    end
    #1;
    check_all();
  endtask

  // Async reset asserted between edges; outputs must return to INIT with no clock.
  task automatic mid_reset();
    #3 rst = 1'b1;
    edges = 0;
    #1;
    check_all();
    chk("rst_tog_out", t_out, INIT_T);
    chk("rst_tog_ready", t_ready, 1'b0);
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, first;
    for (int k = 0; k <= D; k++) hist[k] = '0;

    // 1: reset state, then release with 1010 held
    in_v = 4'b1010;
    #12;
    check_all();
    chk("reset_lvl_out", l_out, INIT_L);
    chk("reset_ready", l_ready, 1'b0);
    @(negedge clk) rst = 1'b0;
    step(); chk("t1_out_e1", l_out, 4'b0000);
    step(); chk("t1_out_e2", l_out, 4'b0000);
    chk("t1_ready_e2", l_ready, 1'b0);
    step(); chk("t1_out_e3", l_out, 4'b1010);
    chk("t1_ready_e3", l_ready, 1'b1);

    // 2: single rise on channel 0
    in_v = 4'b0000;
    repeat (5) step();
    in_v = 4'b0001;
    cnt = 0; first = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (l_rise[0]) cnt++;
      if (first < 0 && l_out[0]) first = i;
    end
    chk("t2_rise_count", cnt, 1);
    chk("t2_latency", first, D);

    // 3: simultaneous fall on ch3 and rise on ch1
    in_v = 4'b1000;
    repeat (5) step();
    in_v = 4'b0010;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (l_rise == 4'b0010 && l_fall == 4'b1000) cnt++;
    end
    chk("t3_pair_cycles", cnt, 1);

    // 4: three spaced toggles on ch2 give three pulses
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 5 || i == 10) in_v[2] = ~in_v[2];
      step();
      if (t_pulse[2]) cnt++;
    end
    chk("t4_pulse_count", cnt, 3);

    // 5: mid-cycle reset with outputs at 1111
    in_v = 4'b1111;
    repeat (5) step();
    chk("t5_pre_out", t_out, 4'b1111);
    mid_reset();
    step(); step();
    chk("t5_ready_e2", t_ready, 1'b0);
    step();
    chk("t5_ready_e3", t_ready, 1'b1);

    // 6: sub-cycle glitch between edges is never sampled
    in_v = 4'b0000;
    repeat (5) step();
    #2 in_v[0] = 1'b1;
    #3 in_v[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (l_rise[0] || l_fall[0]) cnt++;
    end
    chk("t6_glitch_events", cnt, 0);

    // Random stimulus with sparse bit flips and occasional async resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) mid_reset();
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 3) == 0) in_v[b] = ~in_v[b];
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
